exm: RTL and testbench
======================

EXM -- requirements
Module: exm

Interface
REQ-001 clk_i  in  1  single clock; all state on rising edge.
REQ-002 rst_i  in  1  synchronous, active-high reset.
REQ-003 input_ready_o  out  1  exm accepts a decoded instruction this cycle.
REQ-004 input_valid_i  in  1  decode presents a valid instruction.
REQ-005 pc_i  in  32  instruction PC.
REQ-006 alu_operand1_i  in  32  ALU operand 1 / branch compare lhs.
REQ-007 alu_operand2_i  in  32  ALU operand 2 / branch compare rhs.
REQ-008 alu_op_i  in  3  000 ADD, 001/101 SHIFT, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
REQ-009 alu_sub_i  in  1  ADD performs op1-op2.
REQ-010 alu_shift_left_i  in  1  SHIFT direction left, else right.
REQ-011 alu_signed_shift_i  in  1  right shift arithmetic, else logical.
REQ-012 branch_cond_i  in  3  000 none, 001 EQ, 010 NE, 011 LT, 100 GE, 101 LTU, 110 GEU, 111 always.
REQ-013 branch_offset_i  in  20  signed offset in halfwords.
REQ-014 output_ready_i  in  1  load-store stage accepts result.
REQ-015 output_valid_o  out  1  output register holds a valid result.
REQ-016 result_o  out  32  ALU result; load-store address when ls_enable_o.
REQ-017 branch_o  out  1  taken branch, qualified by output_valid_o.
REQ-018 branch_target_o  out  32  pc + sign_extend({branch_offset, 1'b0}).
REQ-019 reg_write_i / reg_write_o  in/out  1  write-back enable pass-through.
REQ-020 reg_addr_i / reg_addr_o  in/out  5  destination register pass-through.
REQ-021 ls_enable_i / ls_enable_o  in/out  1  memory access pass-through.
REQ-022 ls_write_i / ls_write_o  in/out  1  store (1) / load (0) pass-through.
REQ-023 ls_write_data_i / ls_write_data_o  in/out  32  store data pass-through.
REQ-024 ls_sel_i / ls_sel_o  in/out  4  byte select pass-through.
REQ-025 ls_unsigned_load_i / ls_unsigned_load_o  in/out  1  zero-extend load pass-through.

Function
REQ-026 One-stage registered pipeline; handshake transfer when valid and ready both high on a rising edge.
REQ-027 input_ready_o = !rst_i && (!output_valid_o || output_ready_i), combinational, no bubble under continuous flow.
REQ-028 On input transfer, all outputs load from this cycle's inputs; result visible next cycle (latency 1).
REQ-029 output_valid_o set on input transfer; cleared on output transfer with no simultaneous input transfer.
REQ-030 Simultaneous output and input transfer: register replaced, output_valid_o stays 1.
REQ-031 Stall (output_valid_o && !output_ready_i): every output held bit-stable; inputs ignored.
REQ-032 ADD: 32-bit wrap-around sum/difference, carry discarded.
REQ-033 SHIFT: amount = op2[4:0]; left logical; right logical or arithmetic per alu_signed_shift_i.
REQ-034 SLT/SLTU: result 1 if op1 < op2 signed/unsigned, else 0.
REQ-035 Branch compare on op1/op2 independent of alu_op_i; cond 000 gives branch_o 0, 111 gives 1.
REQ-036 branch_target_o wraps modulo 2^32; computed for every instruction regardless of branch_o.
REQ-037 Pass-through fields unmodified; exm never alters reg_write or ls_* values.

Reset
REQ-038 rst_i high at a clock edge: output_valid_o, branch_o, reg_write_o, ls_enable_o, ls_write_o 0; all data outputs 0; input_ready_o 0 while rst_i high; in-flight result discarded; input_ready_o 1 the cycle after deassertion.

Verification
REQ-039 Reset mid-stall (output_valid_o=1, output_ready_i=0) -> next cycle output_valid_o=0, result_o=0.
REQ-040 ADD sub=1, op1=0, op2=1 -> result_o=0xFFFFFFFF one cycle later, output_valid_o=1.
REQ-041 SHIFT right signed, op1=0x80000000, op2=0x21 -> result_o=0xC0000000; unsigned -> 0x40000000.
REQ-042 BLT op1=0xFFFFFFFF, op2=1, pc=0x100, offset=0xFFFFE -> branch_o=1, target=0xFC; BLTU same -> branch_o=0.
REQ-043 output_ready_i=0 three cycles with input_valid_i=1 -> outputs stable, input_ready_o=0; release -> back-to-back results, none lost or duplicated.
REQ-044 Random valid/ready toggling 10k instructions -> in-order results match reference model, pass-through fields exact.

Source files
------------

// File: rtl/exm_if.sv
// exm_if: decode -> exm -> load-store channel bundle.
//   Input side : input_valid_i/input_ready_o handshake, PC, ALU operands and
//                controls, branch condition/offset, pass-through fields (_i).
//   Output side: output_valid_o/output_ready_i handshake, result, branch
//                outcome/target, pass-through fields (_o).
//   slave  modport: the exm stage.
//   master modport: the surrounding pipeline (decode + load-store stage).
interface exm_if;
    // decode -> exm
    logic        input_ready_o;
    logic        input_valid_i;
    logic [31:0] pc_i;
    logic [31:0] alu_operand1_i;
    logic [31:0] alu_operand2_i;
    logic [2:0]  alu_op_i;
    logic        alu_sub_i;
    logic        alu_shift_left_i;
    logic        alu_signed_shift_i;
    logic [2:0]  branch_cond_i;
    logic [19:0] branch_offset_i;
    logic        reg_write_i;
    logic [4:0]  reg_addr_i;
    logic        ls_enable_i;
    logic        ls_write_i;
    logic [31:0] ls_write_data_i;
    logic [3:0]  ls_sel_i;
    logic        ls_unsigned_load_i;
    // exm -> load-store
    logic        output_ready_i;
    logic        output_valid_o;
    logic [31:0] result_o;
    logic        branch_o;
    logic [31:0] branch_target_o;
    logic        reg_write_o;
    logic [4:0]  reg_addr_o;
    logic        ls_enable_o;
    logic        ls_write_o;
    logic [31:0] ls_write_data_o;
    logic [3:0]  ls_sel_o;
    logic        ls_unsigned_load_o;

    modport slave (
        output input_ready_o,
        input  input_valid_i, pc_i, alu_operand1_i, alu_operand2_i, alu_op_i,
               alu_sub_i, alu_shift_left_i, alu_signed_shift_i, branch_cond_i,
               branch_offset_i, reg_write_i, reg_addr_i, ls_enable_i,
               ls_write_i, ls_write_data_i, ls_sel_i, ls_unsigned_load_i,
               output_ready_i,
        output output_valid_o, result_o, branch_o, branch_target_o,
               reg_write_o, reg_addr_o, ls_enable_o, ls_write_o,
               ls_write_data_o, ls_sel_o, ls_unsigned_load_o
    );

    modport master (
        input  input_ready_o,
        output input_valid_i, pc_i, alu_operand1_i, alu_operand2_i, alu_op_i,
               alu_sub_i, alu_shift_left_i, alu_signed_shift_i, branch_cond_i,
               branch_offset_i, reg_write_i, reg_addr_i, ls_enable_i,
               ls_write_i, ls_write_data_i, ls_sel_i, ls_unsigned_load_i,
               output_ready_i,
        input  output_valid_o, result_o, branch_o, branch_target_o,
               reg_write_o, reg_addr_o, ls_enable_o, ls_write_o,
               ls_write_data_o, ls_sel_o, ls_unsigned_load_o
    );
endinterface

// File: rtl/exm.sv
// exm: execute stage. One registered pipeline stage computing the ALU result,
// branch decision and branch target for each accepted instruction, and
// forwarding the write-back / load-store control fields unchanged.
//   clk_i : clock, all state on rising edge
//   rst_i : synchronous active-high reset
//   bus   : exm_if.slave, input handshake + instruction fields, output
//           handshake + registered result/branch/pass-through fields
module exm (
    input  logic  clk_i,
    input  logic  rst_i,
    exm_if.slave  bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned SH_W  = 5;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SLT  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SRL  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_EQ   = 3'b001;
    localparam logic [2:0] BR_NE   = 3'b010;
    localparam logic [2:0] BR_LT   = 3'b011;
    localparam logic [2:0] BR_GE   = 3'b100;
    localparam logic [2:0] BR_LTU  = 3'b101;
    localparam logic [2:0] BR_GEU  = 3'b110;
    localparam logic [2:0] BR_ALW  = 3'b111;

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [SH_W-1:0] shamt;
    logic            lt_s;
    logic            lt_u;
    logic            eq;
    logic [XLEN-1:0] alu_result;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            in_xfer;

    assign op1   = bus.alu_operand1_i;
    assign op2   = bus.alu_operand2_i;
    assign shamt = op2[SH_W-1:0];
    assign lt_s  = $signed(op1) < $signed(op2);
    assign lt_u  = op1 < op2;
    assign eq    = op1 == op2;

    // Accept when the output register is empty or drains this same edge.
    assign bus.input_ready_o = !rst_i && (!bus.output_valid_o || bus.output_ready_i);
    assign in_xfer           = bus.input_valid_i && bus.input_ready_o;

    // ALU datapath
    always_comb begin
        alu_result = '0;
        case (bus.alu_op_i)
            OP_ADD:  alu_result = bus.alu_sub_i ? (op1 - op2) : (op1 + op2);
            OP_SLL,
            OP_SRL: begin
                if (bus.alu_shift_left_i)
                    alu_result = op1 << shamt;
                else if (bus.alu_signed_shift_i)
                    alu_result = XLEN'($signed(op1) >>> shamt);
                else
                    alu_result = op1 >> shamt;
            end
            OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, lt_u};
            OP_XOR:  alu_result = op1 ^ op2;
            OP_OR:   alu_result = op1 | op2;
            OP_AND:  alu_result = op1 & op2;
            default: alu_result = '0;
        endcase
    end

    // Branch decision, independent of the ALU opcode
    always_comb begin
        branch_taken = 1'b0;
        case (bus.branch_cond_i)
            BR_NONE: branch_taken = 1'b0;
            BR_EQ:   branch_taken = eq;
            BR_NE:   branch_taken = !eq;
            BR_LT:   branch_taken = lt_s;
            BR_GE:   branch_taken = !lt_s;
            BR_LTU:  branch_taken = lt_u;
            BR_GEU:  branch_taken = !lt_u;
            BR_ALW:  branch_taken = 1'b1;
            default: branch_taken = 1'b0;
        endcase
    end

    // Offset is in halfwords: append a zero bit, then sign-extend to XLEN.
    assign branch_target = bus.pc_i
                         + {{(XLEN-21){bus.branch_offset_i[19]}}, bus.branch_offset_i, 1'b0};

    // Output register: loads on input transfer, otherwise holds; valid drops
    // only when the output drains with nothing replacing it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.output_valid_o     <= 1'b0;
            bus.result_o           <= '0;
            bus.branch_o           <= 1'b0;
            bus.branch_target_o    <= '0;
            bus.reg_write_o        <= 1'b0;
            bus.reg_addr_o         <= '0;
            bus.ls_enable_o        <= 1'b0;
            bus.ls_write_o         <= 1'b0;
            bus.ls_write_data_o    <= '0;
            bus.ls_sel_o           <= '0;
            bus.ls_unsigned_load_o <= 1'b0;
        end else if (in_xfer) begin
            bus.output_valid_o     <= 1'b1;
            bus.result_o           <= alu_result;
            bus.branch_o           <= branch_taken;
            bus.branch_target_o    <= branch_target;
            bus.reg_write_o        <= bus.reg_write_i;
            bus.reg_addr_o         <= bus.reg_addr_i;
            bus.ls_enable_o        <= bus.ls_enable_i;
            bus.ls_write_o         <= bus.ls_write_i;
            bus.ls_write_data_o    <= bus.ls_write_data_i;
            bus.ls_sel_o           <= bus.ls_sel_i;
            bus.ls_unsigned_load_o <= bus.ls_unsigned_load_i;
        end else if (bus.output_valid_o && bus.output_ready_i) begin
            bus.output_valid_o     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_exm.sv
// tb_exm: directed + random bench for exm with a scoreboard queue of
// expected output payloads.
module tb_exm;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  alu_op;
        logic        sub;
        logic        shl;
        logic        sshift;
        logic [2:0]  cond;
        logic [19:0] off;
        logic        rw;
        logic [4:0]  raddr;
        logic        lse;
        logic        lsw;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        uns;
    } in_t;

    typedef struct packed {
        logic [31:0] result;
        logic        branch;
        logic [31:0] target;
        logic        rw;
        logic [4:0]  raddr;
        logic        lse;
        logic        lsw;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        uns;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exm_if bus();
    exm dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

    int   vectors     = 0;
    int   miscompares = 0;
    int   pushed      = 0;
    bit   after_rst   = 1'b0;
    in_t  cur;
    exp_t q[$];

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Reference model, written independently of the RTL datapath.
    function automatic exp_t model(input in_t x);
        exp_t        r;
        logic [4:0]  sh;
        logic [63:0] t;
        logic        lts, ltu, eq;
        r   = '0;
        sh  = x.op2[4:0];
        lts = (x.op1 ^ 32'h8000_0000) < (x.op2 ^ 32'h8000_0000);
        ltu = x.op1 < x.op2;
        eq  = x.op1 == x.op2;
        case (x.alu_op)
            3'd0: r.result = x.sub ? (x.op1 + ~x.op2 + 32'd1) : (x.op1 + x.op2);
            3'd1, 3'd5: begin
                if (x.shl) r.result = x.op1 << sh;
                else if (x.sshift) begin
                    t = {{32{x.op1[31]}}, x.op1} >> sh;
                    r.result = t[31:0];
                end else r.result = x.op1 >> sh;
            end
            3'd2: r.result = lts ? 32'd1 : 32'd0;
            3'd3: r.result = ltu ? 32'd1 : 32'd0;
            3'd4: r.result = x.op1 ^ x.op2;
            3'd6: r.result = x.op1 | x.op2;
            default: r.result = x.op1 & x.op2;
        endcase
        case (x.cond)
            3'd0: r.branch = 1'b0;
            3'd1: r.branch = eq;
            3'd2: r.branch = !eq;
            3'd3: r.branch = lts;
            3'd4: r.branch = !lts;
            3'd5: r.branch = ltu;
            3'd6: r.branch = !ltu;
            default: r.branch = 1'b1;
        endcase
        r.target = x.pc + 32'($signed({x.off, 1'b0}));
        r.rw = x.rw; r.raddr = x.raddr; r.lse = x.lse; r.lsw = x.lsw;
        r.wdata = x.wdata; r.sel = x.sel; r.uns = x.uns;
        return r;
    endfunction

    function automatic exp_t obs();
        exp_t r;
        r.result = bus.result_o;       r.branch = bus.branch_o;
        r.target = bus.branch_target_o; r.rw    = bus.reg_write_o;
        r.raddr  = bus.reg_addr_o;     r.lse    = bus.ls_enable_o;
        r.lsw    = bus.ls_write_o;     r.wdata  = bus.ls_write_data_o;
        r.sel    = bus.ls_sel_o;       r.uns    = bus.ls_unsigned_load_o;
        return r;
    endfunction

    function automatic in_t rand_in();
        in_t x;
        x.pc = $urandom; x.op1 = $urandom; x.op2 = $urandom;
        if ($urandom_range(3) == 0) x.op2 = x.op1;
        x.alu_op = 3'($urandom); x.sub = 1'($urandom); x.shl = 1'($urandom);
        x.sshift = 1'($urandom); x.cond = 3'($urandom); x.off = 20'($urandom);
        x.rw = 1'($urandom); x.raddr = 5'($urandom); x.lse = 1'($urandom);
        x.lsw = 1'($urandom); x.wdata = $urandom; x.sel = 4'($urandom);
        x.uns = 1'($urandom);
        return x;
    endfunction

    task automatic apply();
        bus.pc_i = cur.pc; bus.alu_operand1_i = cur.op1; bus.alu_operand2_i = cur.op2;
        bus.alu_op_i = cur.alu_op; bus.alu_sub_i = cur.sub;
        bus.alu_shift_left_i = cur.shl; bus.alu_signed_shift_i = cur.sshift;
        bus.branch_cond_i = cur.cond; bus.branch_offset_i = cur.off;
        bus.reg_write_i = cur.rw; bus.reg_addr_i = cur.raddr;
        bus.ls_enable_i = cur.lse; bus.ls_write_i = cur.lsw;
        bus.ls_write_data_i = cur.wdata; bus.ls_sel_i = cur.sel;
        bus.ls_unsigned_load_i = cur.uns;
    endtask

    // One clock: check outputs against the scoreboard, predict the handshakes,
    // advance past the edge and update the scoreboard.
    task automatic cycle();
        bit exp_v, exp_rdy, in_x, out_x;
        #1;
        exp_v   = (q.size() != 0);
        exp_rdy = !rst && (!exp_v || bus.output_ready_i);
        chk("input_ready", 128'(bus.input_ready_o), 128'(exp_rdy));
        chk("output_valid", 128'(bus.output_valid_o), 128'(exp_v));
        if (after_rst)  chk("reset_payload", 128'(obs()), 128'(0));
        else if (exp_v) chk("payload", 128'(obs()), 128'(q[0]));
        in_x  = bus.input_valid_i && exp_rdy;
        out_x = exp_v && bus.output_ready_i;
        @(posedge clk);
        if (rst) begin
            q.delete();
            after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
            if (out_x) void'(q.pop_front());
            if (in_x) begin
                q.push_back(model(cur));
                pushed++;
            end
        end
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ncyc;
        cur = rand_in();
        apply();
        bus.input_valid_i  = 1'b0;
        bus.output_ready_i = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        after_rst = 1'b1;
        cycle();                      // still in reset: ready 0, outputs 0
        rst = 1'b0;
        cycle();                      // ready returns the cycle after release

        // ADD with subtract: 0 - 1 wraps
        cur = rand_in(); cur.alu_op = 3'b000; cur.sub = 1'b1;
        cur.op1 = 32'd0; cur.op2 = 32'd1;
        apply(); bus.input_valid_i = 1'b1;
        cycle();
        chk("sub_wrap", 128'(bus.result_o), 128'(32'hFFFF_FFFF));
        chk("sub_valid", 128'(bus.output_valid_o), 128'(1));

        // Arithmetic then logical right shift by op2[4:0] = 1
        cur = rand_in(); cur.alu_op = 3'b101; cur.shl = 1'b0; cur.sshift = 1'b1;
        cur.op1 = 32'h8000_0000; cur.op2 = 32'h21;
        apply(); cycle();
        chk("sra", 128'(bus.result_o), 128'(32'hC000_0000));
        cur.sshift = 1'b0;
        apply(); cycle();
        chk("srl", 128'(bus.result_o), 128'(32'h4000_0000));

        // BLT taken with negative offset, BLTU not taken
        cur = rand_in(); cur.cond = 3'b011; cur.op1 = 32'hFFFF_FFFF; cur.op2 = 32'd1;
        cur.pc = 32'h100; cur.off = 20'hFFFFE;
        apply(); cycle();
        chk("blt_taken", 128'(bus.branch_o), 128'(1));
        chk("blt_target", 128'(bus.branch_target_o), 128'(32'hFC));
        cur.cond = 3'b101;
        apply(); cycle();
        chk("bltu_not_taken", 128'(bus.branch_o), 128'(0));
        bus.input_valid_i = 1'b0;
        cycle();
        cycle();

        // Three-cycle stall with a waiting instruction, then release
        bus.output_ready_i = 1'b0;
        cur = rand_in(); apply(); bus.input_valid_i = 1'b1;
        cycle();
        cur = rand_in(); apply();
        repeat (3) cycle();
        bus.output_ready_i = 1'b1;
        cycle();
        cur = rand_in(); apply();
        cycle();
        bus.input_valid_i = 1'b0;
        cycle();
        cycle();
        chk("stall_drained", 128'(q.size()), 128'(0));

        // Reset while stalled discards the held result
        bus.output_ready_i = 1'b0;
        cur = rand_in(); cur.alu_op = 3'b110; cur.op1 = 32'h1234_5678;
        apply(); bus.input_valid_i = 1'b1;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        chk("rst_stall_valid", 128'(bus.output_valid_o), 128'(0));
        chk("rst_stall_result", 128'(bus.result_o), 128'(0));
        rst = 1'b0;
        bus.input_valid_i = 1'b0;
        bus.output_ready_i = 1'b1;
        cycle();

        // Random valid/ready toggling, 10k instructions
        pushed = 0;
        ncyc   = 0;
        while (pushed < 10000 && ncyc < 60000) begin
            cur = rand_in(); apply();
            bus.input_valid_i  = ($urandom_range(3) != 0);
            bus.output_ready_i = ($urandom_range(3) != 0);
            cycle();
            ncyc++;
        end
        chk("random_count", 128'(pushed), 128'(10000));
        bus.input_valid_i  = 1'b0;
        bus.output_ready_i = 1'b1;
        repeat (3) cycle();
        chk("random_drained", 128'(q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
